seg_scan_ctrl: RTL and testbench
================================

Name: seg_scan_ctrl

Overview:
- Time-multiplexed scan controller for a 4-digit common-anode 7-segment display that shares one segment bus.
- Takes four pre-decoded, active-low 8-bit segment patterns (dp in bit 7), one per digit, as produced by the board's binary-to-7-segment decoders.
- Walks digit 0→1→2→3 repeatedly, driving one anode at a time.
- Inserts a dead-time blank at the start of each slot to suppress ghosting, and flags each new frame.

Parameters:
- SCAN_DIV, 50000, clock cycles per digit slot (1 ms at 50 MHz; 250 Hz frame rate); must be ≥ 2.
- BLANK_CYCLES, 500, blank cycles at the start of each slot; 0 ≤ BLANK_CYCLES < SCAN_DIV.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- hex0  input  8  active-low segment pattern for digit 0 (rightmost).
- hex1  input  8  pattern for digit 1.
- hex2  input  8  pattern for digit 2.
- hex3  input  8  pattern for digit 3.
- dig_en  input  4  per-digit enable; 0 keeps that anode off for its slot.
- an  output  4  active-low anode selects; bit i = digit i.
- sseg  output  8  active-low shared segment bus.
- frame_tick  output  1  one-cycle pulse marking the start of each digit-0 slot.

Behaviour:
- One clock domain, clk. Reset is synchronous and active-high; every register is cleared on a rising clk edge with reset high.
- Reset values: cnt=0, idx=0, an=4'b1111, sseg=8'hFF, frame_tick=0, latched pattern=8'hFF, latched enable=0.
- Counters:
  - cnt is ceil(log2(SCAN_DIV)) bits wide and increments each cycle.
  - At cnt==SCAN_DIV-1, cnt wraps to 0 and idx (2 bits) increments mod 4, so 3 wraps to 0.
- Outputs are registered and lag (idx,cnt) by one cycle. The output after edge n reflects the counter state held after edge n-1.
- Per slot, using the lagged state:
  - Blank phase (cnt < BLANK_CYCLES): an=1111, sseg=FF.
  - Active phase (cnt ≥ BLANK_CYCLES): an has only bit idx low if the latched enable is 1, otherwise an=1111. sseg = latched pattern if enabled, else FF.
- Latching:
  - hex[idx] and dig_en[idx] are sampled on the edge the active phase begins, i.e. the edge where the lagged cnt==BLANK_CYCLES.
  - The sampled values are held for the rest of the slot.
  - Input changes mid-slot do not appear until that digit's next slot, so there is no tearing.
- With BLANK_CYCLES=0 there is no blank phase; the anode moves directly from one digit to the next on the slot boundary.
- Invariant: at most one bit of an is low in any cycle. No two anodes are ever low simultaneously, including across slot boundaries and reset.
- Disabled digits still consume their full slot. Frame period is always 4*SCAN_DIV cycles.
- frame_tick is high for exactly the one cycle whose lagged state is (idx=0, cnt=0). This includes the first cycle after reset release.
- Timing after reset release (edge 1 = first edge with reset low):
  - Digit 0 blank on edges 1..BLANK_CYCLES.
  - Digit 0 active from edge BLANK_CYCLES+1 through edge SCAN_DIV.
  - Digit 1 slot starts at edge SCAN_DIV+1.
- Reset mid-operation: outputs go blank on the same edge and the counters zero. The sequence restarts at digit 0 exactly as from power-up, with no partial slot.
- If reset and a slot wrap coincide, reset wins.

Test Plan (SCAN_DIV=8, BLANK_CYCLES=2 unless noted; edge numbers count from reset release):
- Reset: hold reset 3 cycles with hex inputs all 00 → an=1111, sseg=FF, frame_tick=0 throughout.
- Scan order: hex0=C0, hex1=F9, hex2=A4, hex3=B0, dig_en=1111. Required response:
  - Edges 1-2 blank; edges 3-8 an=1110, sseg=C0.
  - Edges 9-10 blank; edges 11-16 an=1101, sseg=F9.
  - Edges 19-24 an=1011, sseg=A4; edges 27-32 an=0111, sseg=B0.
  - frame_tick high only at edges 1 and 33.
- Mask: dig_en=1010 → an never drives bit 0 or bit 2 low; sseg=FF during slots 0 and 2; slot timing is unchanged (digit 1 is still active on edges 11-16).
- Mid-slot update: change hex0 from C0 to 92 at edge 5 → sseg stays C0 through edge 8; 92 appears at edge 35.
- Reset mid-frame: assert reset on edge 20 → after edge 20, an=1111 and sseg=FF. After release, digit 0 is active on edges 3-8 relative to the new release, and frame_tick fires on new edge 1.
- BLANK_CYCLES=0: an goes 1110 for edges 1-8, then 1101 from edge 9 with no FF gap; checker confirms at most one an bit is low in every cycle.

Source files
------------

// File: rtl/seg_scan_ctrl.sv
// Scan controller for a 4-digit common-anode 7-segment display on one shared segment bus.
// Latency: outputs are registered and lag the (idx, cnt) scan state by one clock.
// Backpressure: none; free-running scan, and patterns are sampled once per slot at active-phase start.
module seg_scan_ctrl #(
    parameter int SCAN_DIV     = 50000,
    parameter int BLANK_CYCLES = 500
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] hex0,
    input  logic [7:0] hex1,
    input  logic [7:0] hex2,
    input  logic [7:0] hex3,
    input  logic [3:0] dig_en,
    output logic [3:0] an,
    output logic [7:0] sseg,
    output logic       frame_tick
);

    localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] BLANK_C  = CW'(BLANK_CYCLES);

    // Scan state
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    idx_q, idx_d;

    // Per-slot snapshot of the digit pattern and enable, held for the whole active phase
    logic [7:0]    pat_q, pat_d;
    logic          en_q, en_d;

    // Registered outputs
    logic [3:0]    an_q, an_d;
    logic [7:0]    sseg_q, sseg_d;
    logic          tick_q, tick_d;

    logic          in_blank;
    logic          act_start;
    logic [7:0]    cur_pat;

    // With no blank phase the comparison would be constant, so drop it entirely.
    generate
        if (BLANK_CYCLES == 0) begin : g_no_blank
            assign in_blank = 1'b0;
        end else begin : g_blank
            assign in_blank = (cnt_q < BLANK_C);
        end
    endgenerate

    assign act_start = (cnt_q == BLANK_C);

    // Select the pattern for the digit currently owning the bus
    always_comb begin
        cur_pat = 8'hFF;
        case (idx_q)
            2'd0:    cur_pat = hex0;
            2'd1:    cur_pat = hex1;
            2'd2:    cur_pat = hex2;
            default: cur_pat = hex3;
        endcase
    end

    // Slot counter wraps at SCAN_DIV-1 and advances the digit index mod 4
    always_comb begin
        cnt_d = cnt_q + CW'(1);
        idx_d = idx_q;
        if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
            idx_d = idx_q + 2'd1;
        end
    end

    // Output decode from the current scan state; the snapshot is taken at active-phase start
    // and fed straight through on that same edge so the first active cycle shows the new value.
    always_comb begin
        pat_d  = pat_q;
        en_d   = en_q;
        an_d   = 4'b1111;
        sseg_d = 8'hFF;
        tick_d = (idx_q == 2'd0) && (cnt_q == '0);
        if (act_start) begin
            pat_d = cur_pat;
            en_d  = dig_en[idx_q];
        end
        if (!in_blank && en_d) begin
            an_d         = 4'b1111;
            an_d[idx_q]  = 1'b0;
            sseg_d       = pat_d;
        end
    end

    // State and output registers; reset blanks the display on the same edge it is seen
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q  <= '0;
            idx_q  <= 2'd0;
            pat_q  <= 8'hFF;
            en_q   <= 1'b0;
            an_q   <= 4'b1111;
            sseg_q <= 8'hFF;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            idx_q  <= idx_d;
            pat_q  <= pat_d;
            en_q   <= en_d;
            an_q   <= an_d;
            sseg_q <= sseg_d;
            tick_q <= tick_d;
        end
    end

    assign an         = an_q;
    assign sseg       = sseg_q;
    assign frame_tick = tick_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl: two instances (BLANK_CYCLES=2 and 0, SCAN_DIV=8) share all stimulus.
// Expected outputs are queued per edge by the stimulus and popped by a negedge monitor.
// The monitor also enforces the single-anode-low invariant on both instances every cycle.
module tb_seg_scan_ctrl;

    typedef struct packed {
        logic [3:0] an;
        logic [7:0] sseg;
        logic       tick;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] hex0, hex1, hex2, hex3;
    logic [3:0] dig_en;
    logic [3:0] an_a, an_b;
    logic [7:0] sseg_a, sseg_b;
    logic       tick_a, tick_b;

    exp_t qa[$];
    exp_t qb[$];

    logic [7:0] exp_pat [4];
    logic [3:0] exp_en;

    int errors = 0;
    int checks = 0;
    int edge_no = 0;

    always #5 clk = ~clk;

    seg_scan_ctrl #(.SCAN_DIV(8), .BLANK_CYCLES(2)) dut_a (
        .clk(clk), .reset(reset),
        .hex0(hex0), .hex1(hex1), .hex2(hex2), .hex3(hex3),
        .dig_en(dig_en),
        .an(an_a), .sseg(sseg_a), .frame_tick(tick_a)
    );

    seg_scan_ctrl #(.SCAN_DIV(8), .BLANK_CYCLES(0)) dut_b (
        .clk(clk), .reset(reset),
        .hex0(hex0), .hex1(hex1), .hex2(hex2), .hex3(hex3),
        .dig_en(dig_en),
        .an(an_b), .sseg(sseg_b), .frame_tick(tick_b)
    );

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s (edge %0d): got %0h, expected %0h", nm, edge_no, act, exp);
        end
    endtask

    // Monitor: pop one expectation per instance each cycle the DUT presents a queued output
    always @(negedge clk) begin
        exp_t e;
        if (qa.size() > 0) begin
            e = qa.pop_front();
            chk("a_an",   int'(an_a),   int'(e.an));
            chk("a_sseg", int'(sseg_a), int'(e.sseg));
            chk("a_tick", int'(tick_a), int'(e.tick));
        end
        if (qb.size() > 0) begin
            e = qb.pop_front();
            chk("b_an",   int'(an_b),   int'(e.an));
            chk("b_sseg", int'(sseg_b), int'(e.sseg));
            chk("b_tick", int'(tick_b), int'(e.tick));
        end
        if (edge_no > 0) begin
            chk("a_onehot", ($countones(~an_a) <= 1) ? 1 : 0, 1);
            chk("b_onehot", ($countones(~an_b) <= 1) ? 1 : 0, 1);
        end
    end

    // Expected response for edge e after reset release: slot = (e-1)/8 mod 4, position (e-1) mod 8
    function automatic exp_t model(input int e, input int blank);
        exp_t r;
        int slot, pos;
        slot   = ((e - 1) / 8) % 4;
        pos    = (e - 1) % 8;
        r.tick = (slot == 0) && (pos == 0);
        r.an   = 4'b1111;
        r.sseg = 8'hFF;
        if (pos >= blank && exp_en[slot]) begin
            r.an   = ~(4'b0001 << slot);
            r.sseg = exp_pat[slot];
        end
        return r;
    endfunction

    task automatic push_blank();
        exp_t r;
        r.an   = 4'b1111;
        r.sseg = 8'hFF;
        r.tick = 1'b0;
        qa.push_back(r);
        qb.push_back(r);
    endtask

    // Hold reset for k edges (all expected blank), then release before the next edge
    task automatic do_reset(input int k);
        reset = 1'b1;
        for (int i = 0; i < k; i++) begin
            @(posedge clk);
            #1;
            edge_no = 0;
            push_blank();
        end
        reset = 1'b0;
    endtask

    // Run n edges from reset release; mid=1 changes hex0 mid-slot at edge 5
    task automatic run_edges(input int n, input bit mid);
        for (int e = 1; e <= n; e++) begin
            @(posedge clk);
            #1;
            edge_no = e;
            qa.push_back(model(e, 2));
            qb.push_back(model(e, 0));
            if (mid && e == 5) hex0 = 8'h92;
            // Slot 0 next latches at edge 35 (blank) / 33 (no blank); C0 remains until then
            if (mid && e == 20) exp_pat[0] = 8'h92;
        end
    endtask

    initial begin
        reset  = 1'b1;
        hex0   = 8'h00;
        hex1   = 8'h00;
        hex2   = 8'h00;
        hex3   = 8'h00;
        dig_en = 4'b1111;
        exp_en = 4'b1111;
        exp_pat[0] = 8'hC0;
        exp_pat[1] = 8'hF9;
        exp_pat[2] = 8'hA4;
        exp_pat[3] = 8'hB0;

        // Reset held with all-zero patterns: display must stay dark
        do_reset(3);

        // Scan order, frame ticks at 1 and 33, mid-slot update of digit 0
        hex0 = 8'hC0; hex1 = 8'hF9; hex2 = 8'hA4; hex3 = 8'hB0;
        run_edges(40, 1'b1);

        // Reset mid-frame at edge 20, then restart from digit 0
        hex0 = 8'hC0;
        exp_pat[0] = 8'hC0;
        do_reset(2);
        run_edges(19, 1'b0);
        do_reset(2);
        run_edges(10, 1'b0);

        // Masked digits 0 and 2 keep their slots but stay dark
        dig_en = 4'b1010;
        exp_en = 4'b1010;
        do_reset(1);
        run_edges(34, 1'b0);

        @(negedge clk);
        @(negedge clk);
        chk("qa_drained", qa.size(), 0);
        chk("qb_drained", qb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
